// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
// Imported by the converter top and its digit encoder.
package bcd_pkg;

    localparam logic [1:0] CODE_8421 = 2'b00;
    localparam logic [1:0] CODE_XS3  = 2'b01;
    localparam logic [1:0] CODE_2421 = 2'b10;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ENCODE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_encode.sv
// Maps one decimal digit (0..9) onto the selected 4-bit decimal code.
// Code 2'b11 falls back to plain 8421.
module bcd_digit_encode
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic [1:0]         i_code,
    output logic [DIGIT_W-1:0] o_code
);

    always_comb begin
        o_code = i_digit;
        unique case (i_code)
            CODE_XS3:  o_code = i_digit + 4'd3;
            CODE_2421: o_code = (i_digit < 4'd5) ? i_digit : i_digit + 4'd6;
            default:   o_code = i_digit;
        endcase
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a final encode stage selecting 8421, excess-3 or 2421 output code.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    input  logic [1:0]                code_sel,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      ovf
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_shift;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sticky;
    logic [1:0]         r_code;

    logic [ACC_W-1:0]   w_adj;
    logic [ACC_W-1:0]   w_acc_sh;
    logic [BIN_W-1:0]   w_shift_sh;
    logic               w_carry;
    logic [ACC_W-1:0]   w_enc;

    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_acc[i*DIGIT_W +: DIGIT_W] >= 4'd5)
                w_adj[i*DIGIT_W +: DIGIT_W] = r_acc[i*DIGIT_W +: DIGIT_W] + 4'd3;
        end
    end

    // A carry out of the top digit means the value needs more digits.
    assign {w_carry, w_acc_sh, w_shift_sh} = {w_adj, r_shift, 1'b0};

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        bcd_digit_encode u_enc (
            .i_digit (r_acc[g*DIGIT_W +: DIGIT_W]),
            .i_code  (r_code),
            .o_code  (w_enc[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_next = ST_SHIFT;
            ST_SHIFT:  if (r_cnt == CNT_W'(1)) w_next = ST_ENCODE;
            ST_ENCODE: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_code   <= CODE_8421;
            bcd_out  <= '0;
            ovf      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift  <= bin_in;
                        r_acc    <= '0;
                        r_cnt    <= CNT_W'(BIN_W);
                        r_sticky <= 1'b0;
                        r_code   <= code_sel;
                    end
                end
                ST_SHIFT: begin
                    r_acc    <= w_acc_sh;
                    r_shift  <= w_shift_sh;
                    r_sticky <= r_sticky | w_carry;
                    r_cnt    <= r_cnt - CNT_W'(1);
                end
                ST_ENCODE: begin
                    bcd_out <= w_enc;
                    ovf     <= r_sticky;
                end
                default: ;
            endcase
        end
    end

endmodule
